// File: rtl/ecc_scalar_mul_seq_pkg.sv
// Shared constants and state encoding for the ECC scalar-multiply sequencer.
// The point at infinity is all-ones in both coordinates.
package ecc_scalar_mul_seq_pkg;
  localparam int MAX_BITS = 8;
  localparam logic [MAX_BITS-1:0] ECC_INF = '1;
  localparam logic PA_OP_DBL = 1'b0;
  localparam logic PA_OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/ecc_scalar_mul_seq.sv
// Left-to-right double-and-add-always scalar multiply Q = k*P.
// Steers points through one external point-add/double engine.
module ecc_scalar_mul_seq
  import ecc_scalar_mul_seq_pkg::*;
#(
  parameter int WIDTH = MAX_BITS,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_pa_start,
  output logic             o_pa_op,
  output logic             o_pa_add,
  output logic [WIDTH-1:0] o_pa_x1,
  output logic [WIDTH-1:0] o_pa_y1,
  output logic [WIDTH-1:0] o_pa_x2,
  output logic [WIDTH-1:0] o_pa_y2,
  input  logic             i_pa_finish,
  input  logic [WIDTH-1:0] i_pa_x,
  input  logic [WIDTH-1:0] i_pa_y
);
  localparam logic [WIDTH-1:0] INF = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_px;
  logic [WIDTH-1:0] r_py;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_ry;
  logic [CNT_W-1:0] r_idx;
  logic             r_skip;

  logic w_bit;
  logic w_last;
  logic w_r_inf;
  logic w_skip_add;
  logic w_go;

  assign w_bit      = r_k[r_idx];
  assign w_last     = (r_idx == '0);
  assign w_r_inf    = (r_rx == INF) && (r_ry == INF);
  assign w_skip_add = w_r_inf && w_bit;
  // a skipped request advances without consuming an engine finish
  assign w_go       = r_skip || i_pa_finish;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_idx      <= '0;
      r_skip     <= 1'b0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_result_x <= '0;
      o_result_y <= '0;
      o_pa_start <= 1'b0;
      o_pa_op    <= 1'b0;
      o_pa_add   <= 1'b0;
      o_pa_x1    <= '0;
      o_pa_y1    <= '0;
      o_pa_x2    <= '0;
      o_pa_y2    <= '0;
    end else begin
      o_finished <= 1'b0;
      o_pa_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k     <= i_k;
            r_px    <= i_x;
            r_py    <= i_y;
            r_idx   <= CNT_W'(WIDTH - 1);
            o_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_bit) begin
            r_rx <= r_px;
            r_ry <= r_py;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_DBL_REQ;
            end
          end else if (w_last) begin
            r_rx    <= INF;
            r_ry    <= INF;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DBL_REQ: begin
          r_skip     <= w_r_inf;
          o_pa_start <= !w_r_inf;
          o_pa_op    <= PA_OP_DBL;
          o_pa_add   <= 1'b0;
          o_pa_x1    <= r_rx;
          o_pa_y1    <= r_ry;
          o_pa_x2    <= r_rx;
          o_pa_y2    <= r_ry;
          r_state    <= S_DBL_WAIT;
        end
        S_DBL_WAIT: begin
          if (w_go) begin
            if (!r_skip) begin
              r_rx <= i_pa_x;
              r_ry <= i_pa_y;
            end
            r_skip  <= 1'b0;
            r_state <= S_ADD_REQ;
          end
        end
        S_ADD_REQ: begin
          r_skip     <= w_skip_add;
          o_pa_start <= !w_skip_add;
          o_pa_op    <= PA_OP_ADD;
          o_pa_add   <= w_bit;
          o_pa_x1    <= r_rx;
          o_pa_y1    <= r_ry;
          o_pa_x2    <= r_px;
          o_pa_y2    <= r_py;
          if (w_skip_add) begin
            r_rx <= r_px;
            r_ry <= r_py;
          end
          r_state <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (w_go) begin
            if (!r_skip) begin
              r_rx <= i_pa_x;
              r_ry <= i_pa_y;
            end
            r_skip <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_DBL_REQ;
            end
          end
        end
        S_DONE: begin
          o_result_x <= r_rx;
          o_result_y <= r_ry;
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scalar_mul_seq.sv
// Scoreboard bench for ecc_scalar_mul_seq on y^2=x^3+2x+2 mod 17, P=(5,1).
// A behavioural point engine answers start pulses after 3-10 cycles.
module tb_ecc_scalar_mul_seq;
  localparam int W = 8;
  localparam logic [W-1:0] INF = '1;
  localparam int MODP = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] k = '0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         o_busy, o_finished;
  logic [W-1:0] o_result_x, o_result_y;
  logic         o_pa_start, o_pa_op, o_pa_add;
  logic [W-1:0] o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2;
  logic         pa_fin;
  logic [W-1:0] pa_x, pa_y;

  always #5 clk = ~clk;

  ecc_scalar_mul_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_k(k), .i_x(x), .i_y(y),
    .o_busy(o_busy), .o_finished(o_finished),
    .o_result_x(o_result_x), .o_result_y(o_result_y),
    .o_pa_start(o_pa_start), .o_pa_op(o_pa_op), .o_pa_add(o_pa_add),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1),
    .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2),
    .i_pa_finish(pa_fin), .i_pa_x(pa_x), .i_pa_y(pa_y)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int starts;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int md(input int a);
    int r;
    r = a % MODP;
    return (r < 0) ? r + MODP : r;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < MODP; i++)
      if (md(a * i) == 1) return i;
    return 0;
  endfunction

  function automatic void ec_add(input int x1, input int y1,
                                 input int x2, input int y2,
                                 output int xr, output int yr);
    int l;
    if (x1 == 255 && y1 == 255) begin xr = x2; yr = y2; return; end
    if (x2 == 255 && y2 == 255) begin xr = x1; yr = y1; return; end
    if (x1 == x2 && md(y1 + y2) == 0) begin xr = 255; yr = 255; return; end
    if (x1 == x2) l = md((3 * x1 * x1 + 2) * inv(md(2 * y1)));
    else l = md((y2 - y1) * inv(md(x2 - x1)));
    xr = md(l * l - x1 - x2);
    yr = md(l * (x1 - xr) - y1);
  endfunction

  // engine model: result after a random latency, operands must not move
  int eng_cnt = 0;
  int eng_starts = 0;
  int ex_r, ey_r;
  logic [W-1:0] res_x, res_y;
  logic [33:0] lops;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt <= 0;
      pa_fin  <= 1'b0;
      pa_x    <= '0;
      pa_y    <= '0;
    end else begin
      pa_fin <= 1'b0;
      if (o_pa_start) begin
        if (o_pa_op && !o_pa_add) begin
          ex_r = int'(o_pa_x1);
          ey_r = int'(o_pa_y1);
        end else begin
          ec_add(int'(o_pa_x1), int'(o_pa_y1), int'(o_pa_x2),
                 int'(o_pa_y2), ex_r, ey_r);
        end
        res_x <= W'(ex_r);
        res_y <= W'(ey_r);
        lops <= {o_pa_op, o_pa_add, o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2};
        eng_cnt <= int'($urandom_range(10, 3));
        eng_starts <= eng_starts + 1;
      end else if (eng_cnt != 0) begin
        if (eng_cnt == 1) begin
          check("pa_operand_hold",
                {o_pa_op, o_pa_add, o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2},
                lops);
          pa_fin <= 1'b1;
          pa_x   <= res_x;
          pa_y   <= res_y;
        end
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // monitor: compare every finish against the oldest expectation
  int busy_cyc = 0;
  int start_base = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cyc   = 0;
      start_base = eng_starts;
    end else begin
      if (o_busy) busy_cyc++;
      if (o_finished) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finish actual=finish required=none");
        end else begin
          e_cur = sb.pop_front();
          check("result_x", o_result_x, e_cur.x);
          check("result_y", o_result_y, e_cur.y);
          if (e_cur.starts >= 0)
            check("pa_starts", eng_starts - start_base, e_cur.starts);
          if (e_cur.lat >= 0)
            check("latency", busy_cyc, e_cur.lat);
        end
        busy_cyc   = 0;
        start_base = eng_starts;
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!o_finished && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!o_finished) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=no_finish required=finish");
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] kk);
    @(negedge clk);
    k = kk;
    x = 8'd5;
    y = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] kk, input logic [W-1:0] ex,
                        input logic [W-1:0] ey, input int es, input int el);
    exp_t e;
    e.x = ex;
    e.y = ey;
    e.starts = es;
    e.lat = el;
    sb.push_back(e);
    issue(kk);
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_finished"}, o_finished, 0);
    check({tag, "_pa_start"}, o_pa_start, 0);
    check({tag, "_result"}, {o_result_x, o_result_y}, 0);
    check({tag, "_pa_ops"},
          {o_pa_op, o_pa_add, o_pa_x1, o_pa_y1, o_pa_x2, o_pa_y2}, 0);
  endtask

  initial begin
    exp_t e;
    int n;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b0;

    run_op(8'd0, INF, INF, 0, W + 1);
    run_op(8'd1, 8'd5, 8'd1, 0, W + 1);
    run_op(8'd2, 8'd6, 8'd3, 2, -1);
    run_op(8'd3, 8'd10, 8'd6, 2, -1);
    run_op(8'd19, INF, INF, -1, -1);
    run_op(8'd20, 8'd5, 8'd1, -1, -1);
    run_op(8'd39, 8'd5, 8'd1, -1, -1);
    run_op(8'd38, INF, INF, -1, -1);
    run_op(8'd5, 8'd9, 8'd16, -1, -1);
    run_op(8'd128, 8'd9, 8'd1, -1, -1);
    run_op(8'd255, 8'd13, 8'd7, -1, -1);

    // a second start while busy must be dropped
    e.x = 8'd10;
    e.y = 8'd6;
    e.starts = 2;
    e.lat = -1;
    sb.push_back(e);
    issue(8'd3);
    repeat (4) @(negedge clk);
    k = 8'd20;
    x = 8'd9;
    y = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_hold", o_busy, 1);
    wait_done();

    // reset while the engine is busy with an ADD
    issue(8'd3);
    n = 0;
    while (!(o_pa_start && o_pa_op) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_add_wait", o_pa_start && o_pa_op, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(8'd3, 8'd10, 8'd6, 2, -1);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
